// File: rtl/scope_pkg.sv
// Shared types for the scope capture controller: FSM states, sample width and
// the {ch1, ch0} sample pair written into the capture buffer.
package scope_pkg;

  localparam int SAMPLE_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] ch1;
    logic [SAMPLE_W-1:0] ch0;
  } pair_t;

endpackage

// File: rtl/scope_trig_detect.sv
// Slope/threshold crossing test between two consecutive stored samples.
module scope_trig_detect
  import scope_pkg::*;
(
  input  logic [SAMPLE_W-1:0] prev,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                fall,
  output logic                hit
);

  always_comb begin
    if (fall) hit = (prev > level) && (cur <= level);
    else      hit = (prev < level) && (cur >= level);
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture controller: pairs ADC results, decimates, writes a ring
// buffer and records PRETRIG samples before and DEPTH-PRETRIG from the trigger.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int PRETRIG      = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_done,
  input  logic [SAMPLE_W-1:0]   i_data0,
  input  logic [SAMPLE_W-1:0]   i_data1,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_auto,
  input  logic                  i_trig_ch,
  input  logic                  i_trig_fall,
  input  logic [SAMPLE_W-1:0]   i_trig_level,
  input  logic [7:0]            i_decim,
  output logic                  o_wr_en,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [2*SAMPLE_W-1:0] o_wr_data,
  output logic [2:0]            o_state,
  output logic                  o_capture_done,
  output logic                  o_forced,
  output logic [ADDR_W-1:0]     o_start_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

  state_e            state_q, state_d;
  logic              done_q, parity_q;
  logic [7:0]        dec_q, dec_d, dec_lim_q, dec_lim_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  pair_t             prev_q, prev_d, wr_data_q, wr_data_d;
  logic              prev_vld_q, prev_vld_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d, trig_addr_q, trig_addr_d, start_q, start_d;
  logic              cap_done_q, cap_done_d, forced_q, forced_d;

  pair_t             cur_pair;
  logic              done_edge, pair_evt, capturing, store, hit, force_now, trig;
  logic [SAMPLE_W-1:0] prev_sel, cur_sel;

  assign cur_pair  = pair_t'({i_data1, i_data0});
  assign done_edge = i_done & ~done_q;
  // Every second conversion-done edge completes a channel pair.
  assign pair_evt  = done_edge & parity_q;
  assign capturing = state_q inside {PREFILL, ARMED, POST};
  assign store     = pair_evt & capturing & (dec_q == 8'd0);
  assign prev_sel  = i_trig_ch ? prev_q.ch1 : prev_q.ch0;
  assign cur_sel   = i_trig_ch ? i_data1 : i_data0;
  assign force_now = i_auto & (to_q == TO_MAX);
  assign trig      = (state_q == ARMED) & store & ((prev_vld_q & hit) | force_now);

  scope_trig_detect u_trig (
    .prev  (prev_sel),
    .cur   (cur_sel),
    .level (i_trig_level),
    .fall  (i_trig_fall),
    .hit   (hit)
  );

  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    dec_lim_d   = dec_lim_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    cap_done_d  = cap_done_q;
    forced_d    = forced_q;
    start_d     = start_q;

    if (wr_en_q) addr_d = addr_q + ADDR_W'(1);

    // A new decimation ratio is only picked up when the counter wraps.
    if (pair_evt && capturing) begin
      if (dec_q == dec_lim_q) begin
        dec_d     = 8'd0;
        dec_lim_d = i_decim;
      end else begin
        dec_d = dec_q + 8'd1;
      end
    end

    if (store) begin
      wr_en_d    = 1'b1;
      wr_data_d  = cur_pair;
      prev_d     = cur_pair;
      prev_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (i_arm && !i_abort) begin
          state_d    = PREFILL;
          addr_d     = '0;
          cnt_d      = '0;
          to_d       = '0;
          dec_d      = 8'd0;
          dec_lim_d  = i_decim;
          prev_vld_d = 1'b0;
          cap_done_d = 1'b0;
          forced_d   = 1'b0;
        end
      end
      PREFILL: begin
        if (store) begin
          if (cnt_q == PRE_LAST) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ARMED: begin
        if (trig) begin
          trig_addr_d = addr_q;
          forced_d    = ~(prev_vld_q & hit);
          // The trigger pair is itself the first post-trigger sample.
          if (POST_LAST == '0) begin
            state_d    = DONE;
            cap_done_d = 1'b1;
            start_d    = addr_q - PRE_OFS;
          end else begin
            state_d = POST;
            cnt_d   = CNT_W'(1);
          end
        end else if (store && (to_q != TO_MAX)) begin
          to_d = to_q + TO_W'(1);
        end
      end
      POST: begin
        if (store) begin
          if (cnt_q == POST_LAST) begin
            state_d    = DONE;
            cap_done_d = 1'b1;
            start_d    = trig_addr_q - PRE_OFS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_abort) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      parity_q    <= 1'b0;
      dec_q       <= 8'd0;
      dec_lim_q   <= 8'd0;
      cnt_q       <= '0;
      to_q        <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      addr_q      <= '0;
      trig_addr_q <= '0;
      cap_done_q  <= 1'b0;
      forced_q    <= 1'b0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= i_done;
      parity_q    <= parity_q ^ done_edge;
      dec_q       <= dec_d;
      dec_lim_q   <= dec_lim_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      addr_q      <= addr_d;
      trig_addr_q <= trig_addr_d;
      cap_done_q  <= cap_done_d;
      forced_q    <= forced_d;
      start_q     <= start_d;
    end
  end

  assign o_wr_en        = wr_en_q;
  assign o_wr_addr      = addr_q;
  assign o_wr_data      = wr_data_q;
  assign o_state        = state_q;
  assign o_capture_done = cap_done_q;
  assign o_forced       = forced_q;
  assign o_start_addr   = start_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: ramp/constant/random sample streams, with the
// expected record derived from the list of stored samples.
module tb_scope_capture_ctrl;
  import scope_pkg::*;

  localparam int ADDR_W   = 4;
  localparam int PRETRIG  = 4;
  localparam int AUTO_TO  = 8;
  localparam int DEPTH    = 16;
  localparam int POST_LEN = DEPTH - PRETRIG;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_done = 1'b0, i_arm = 1'b0, i_abort = 1'b0, i_auto = 1'b0;
  logic        i_trig_ch = 1'b0, i_trig_fall = 1'b0;
  logic [9:0]  i_data0 = '0, i_data1 = '0, i_trig_level = '0;
  logic [7:0]  i_decim = '0;
  logic        o_wr_en, o_capture_done, o_forced;
  logic [3:0]  o_wr_addr, o_start_addr;
  logic [19:0] o_wr_data;
  logic [2:0]  o_state;

  int checks = 0;
  int failures = 0;
  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  int smp_q[$];
  int oth_q[$];

  always #5 clk = ~clk;

  scope_capture_ctrl #(.ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_done(i_done), .i_data0(i_data0), .i_data1(i_data1),
    .i_arm(i_arm), .i_abort(i_abort), .i_auto(i_auto), .i_trig_ch(i_trig_ch),
    .i_trig_fall(i_trig_fall), .i_trig_level(i_trig_level), .i_decim(i_decim),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_state(o_state),
    .o_capture_done(o_capture_done), .o_forced(o_forced), .o_start_addr(o_start_addr)
  );

  always @(negedge clk) if (o_wr_en) wr_q.push_back({o_wr_addr, o_wr_data});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input int d0, input int d1, input bit ab, input bit rst);
    i_data0 = 10'(d0); i_data1 = 10'(d1);
    i_done = 1'b1; i_abort = ab; i_rst = rst;
    tick(1);
    i_done = 1'b0; i_abort = 1'b0; i_rst = 1'b0;
    tick(31);
  endtask

  task automatic send_pair(input int v, input int o, input bit ab, input bit rst);
    int d0, d1;
    d0 = i_trig_ch ? o : v;
    d1 = i_trig_ch ? v : o;
    done_pulse(d0, d1, 1'b0, 1'b0);
    done_pulse(d0, d1, ab, rst);
  endtask

  task automatic pulse_arm();
    i_arm = 1'b1; tick(1); i_arm = 1'b0; tick(1);
  endtask

  task automatic pulse_abort();
    i_abort = 1'b1; tick(1); i_abort = 1'b0; tick(1);
  endtask

  task automatic make_ramp(input int start, input int step, input int n);
    int v;
    smp_q.delete(); oth_q.delete();
    for (int i = 0; i < n; i++) begin
      v = start + i * step;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      smp_q.push_back(v);
      oth_q.push_back(int'($urandom_range(0, 1023)));
    end
  endtask

  function automatic bit crosses(int p, int c, int lvl, bit fall);
    return fall ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
  endfunction

  function automatic logic [19:0] pair_data(int idx, bit ch);
    return ch ? {10'(smp_q[idx]), 10'(oth_q[idx])} : {10'(oth_q[idx]), 10'(smp_q[idx])};
  endfunction

  task automatic run_capture(input string name, input int dec, input bit ch, input bit fall,
                             input int level, input bit au);
    int sv[$];
    int trig_k, n_wr, n_pairs;
    bit exp_forced;
    logic [23:0] got, ex_v;
    i_trig_ch = ch; i_trig_fall = fall; i_trig_level = 10'(level);
    i_auto = au; i_decim = 8'(dec);
    for (int k = 0; k * (dec + 1) < smp_q.size(); k++) sv.push_back(smp_q[k * (dec + 1)]);
    trig_k = -1; exp_forced = 1'b0;
    for (int k = PRETRIG; k < sv.size() && trig_k < 0; k++) begin
      if (crosses(sv[k-1], sv[k], level, fall)) trig_k = k;
      else if (au && (k - PRETRIG) >= AUTO_TO) begin trig_k = k; exp_forced = 1'b1; end
    end
    if (trig_k < 0) trig_k = sv.size();
    n_wr = trig_k + POST_LEN;
    n_pairs = (n_wr - 1) * (dec + 1) + 1;
    exp_q.delete();
    for (int k = 0; k < n_wr; k++) exp_q.push_back({4'(k % DEPTH), pair_data(k * (dec + 1), ch)});
    wr_q.delete();
    pulse_arm();
    checks++;
    if (o_state !== PREFILL) begin
      failures++; $display("FAIL %s_arm_state got=%0d exp=%0d", name, o_state, PREFILL);
    end
    for (int i = 0; i < n_pairs + 2 && i < smp_q.size(); i++) send_pair(smp_q[i], oth_q[i], 1'b0, 1'b0);
    checks++;
    if (wr_q.size() != n_wr) begin
      failures++; $display("FAIL %s_write_count got=%0d exp=%0d", name, wr_q.size(), n_wr);
    end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      ex_v = exp_q.pop_front(); got = wr_q.pop_front();
      checks++;
      if (got !== ex_v) begin
        failures++; $display("FAIL %s_write got=%h exp=%h", name, got, ex_v);
      end
    end
    checks++;
    if (o_state !== DONE || o_capture_done !== 1'b1) begin
      failures++; $display("FAIL %s_done got state=%0d done=%b exp state=%0d done=1", name, o_state, o_capture_done, DONE);
    end
    checks++;
    if (o_start_addr !== 4'((trig_k - PRETRIG) % DEPTH)) begin
      failures++; $display("FAIL %s_start_addr got=%0d exp=%0d", name, o_start_addr, (trig_k - PRETRIG) % DEPTH);
    end
    checks++;
    if (o_forced !== exp_forced) begin
      failures++; $display("FAIL %s_forced got=%b exp=%b", name, o_forced, exp_forced);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_state !== IDLE || o_wr_en !== 1'b0 || o_wr_addr !== 4'd0 || o_wr_data !== 20'd0 ||
        o_capture_done !== 1'b0 || o_forced !== 1'b0 || o_start_addr !== 4'd0) begin
      failures++;
      $display("FAIL %s got state=%0d en=%b addr=%0d data=%h done=%b forced=%b start=%0d exp all zero",
               name, o_state, o_wr_en, o_wr_addr, o_wr_data, o_capture_done, o_forced, o_start_addr);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; tick(2); i_rst = 1'b0; tick(1);
    check_all_zero("reset");
  endtask

  task automatic test_rising();
    make_ramp(0, 10, 80);
    run_capture("rising", 0, 1'b0, 1'b0, 35, 1'b0);
  endtask

  task automatic test_falling();
    make_ramp(100, -10, 80);
    run_capture("falling", 0, 1'b1, 1'b1, 35, 1'b0);
    // Rises through the level in ARMED first; only the later fall may trigger.
    make_ramp(0, 10, 80);
    for (int i = 6; i < 80; i++) smp_q[i] = (100 - 10 * i < 0) ? 0 : 100 - 10 * i;
    run_capture("fall_ignores_rise", 0, 1'b0, 1'b1, 35, 1'b0);
  endtask

  task automatic test_decim();
    make_ramp(0, 10, 80);
    run_capture("decim2", 2, 1'b0, 1'b0, 100, 1'b0);
  endtask

  task automatic test_auto();
    make_ramp(50, 0, 80);
    run_capture("auto", 0, 1'b1, 1'b0, 35, 1'b1);
  endtask

  task automatic test_abort_post();
    make_ramp(0, 10, 80);
    i_trig_ch = 1'b0; i_trig_fall = 1'b0; i_trig_level = 10'd35; i_auto = 1'b0; i_decim = 8'd0;
    wr_q.delete();
    pulse_arm();
    for (int i = 0; i < 7; i++) send_pair(smp_q[i], oth_q[i], 1'b0, 1'b0);
    checks++;
    if (o_state !== POST) begin
      failures++; $display("FAIL abort_pre_state got=%0d exp=%0d", o_state, POST);
    end
    send_pair(smp_q[7], oth_q[7], 1'b1, 1'b0);
    send_pair(smp_q[8], oth_q[8], 1'b0, 1'b0);
    checks++;
    if (wr_q.size() != 7 || o_state !== IDLE) begin
      failures++; $display("FAIL abort_post got writes=%0d state=%0d exp writes=7 state=%0d", wr_q.size(), o_state, IDLE);
    end
    make_ramp(0, 10, 80);
    run_capture("rearm", 0, 1'b0, 1'b0, 35, 1'b0);
  endtask

  task automatic test_reset_mid_prefill();
    make_ramp(0, 10, 80);
    i_trig_ch = 1'b0; i_trig_fall = 1'b0; i_trig_level = 10'd35; i_auto = 1'b0; i_decim = 8'd0;
    wr_q.delete();
    pulse_arm();
    send_pair(smp_q[0], oth_q[0], 1'b0, 1'b0);
    send_pair(smp_q[1], oth_q[1], 1'b0, 1'b0);
    send_pair(smp_q[2], oth_q[2], 1'b0, 1'b1);
    check_all_zero("reset_mid_prefill");
    checks++;
    if (wr_q.size() != 2) begin
      failures++; $display("FAIL reset_write_count got=%0d exp=2", wr_q.size());
    end
  endtask

  task automatic test_arm_ignored();
    logic [23:0] last;
    make_ramp(50, 0, 80);
    i_trig_ch = 1'b0; i_trig_fall = 1'b0; i_trig_level = 10'd35; i_auto = 1'b0; i_decim = 8'd0;
    wr_q.delete();
    pulse_arm();
    for (int i = 0; i < 6; i++) send_pair(smp_q[i], oth_q[i], 1'b0, 1'b0);
    pulse_arm();
    checks++;
    if (o_state !== ARMED) begin
      failures++; $display("FAIL arm_ignored_state got=%0d exp=%0d", o_state, ARMED);
    end
    send_pair(smp_q[6], oth_q[6], 1'b0, 1'b0);
    last = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 24'hffffff;
    checks++;
    if (wr_q.size() != 7 || last !== {4'd6, pair_data(6, 1'b0)}) begin
      failures++; $display("FAIL arm_ignored_addr got writes=%0d last=%h exp writes=7 last=%h",
                           wr_q.size(), last, {4'd6, pair_data(6, 1'b0)});
    end
    pulse_abort();
    checks++;
    if (o_state !== IDLE) begin
      failures++; $display("FAIL abort_armed got=%0d exp=%0d", o_state, IDLE);
    end
  endtask

  task automatic test_random();
    bit fall, ch;
    int dec, lvl;
    for (int n = 0; n < 3; n++) begin
      fall = 1'($urandom_range(0, 1));
      ch   = 1'($urandom_range(0, 1));
      dec  = int'($urandom_range(0, 2));
      lvl  = int'($urandom_range(0, 700));
      if (fall) make_ramp(int'($urandom_range(500, 700)), -int'($urandom_range(1, 20)), 80);
      else      make_ramp(int'($urandom_range(0, 200)), int'($urandom_range(1, 20)), 80);
      run_capture($sformatf("random%0d", n), dec, ch, fall, lvl, 1'b1);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_rising();
    test_falling();
    test_decim();
    test_auto();
    test_abort_post();
    test_reset_mid_prefill();
    test_arm_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_capture_ctrl.md
SCOPE_CAPTURE_CTRL -- requirements
Module: scope_capture_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, capture buffer address width; DEPTH = 2**ADDR_W.
REQ-002 Parameter: PRETRIG, 256, samples kept before trigger; legal range 1..DEPTH-1.
REQ-003 Parameter: AUTO_TIMEOUT, 4096, stored samples in ARMED before a forced trigger in auto mode.
REQ-004 i_clk  in  1  single clock; all logic on posedge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_done  in  1  ADC conversion-done pulse, one i_clk cycle wide.
REQ-007 i_data0 / i_data1  in  10 each  latest ADC channel 0 / channel 1 results, valid while i_done is high.
REQ-008 i_arm / i_abort  in  1 each  start-capture pulse / return-to-IDLE pulse.
REQ-009 i_auto  in  1  auto mode: force a trigger after AUTO_TIMEOUT.
REQ-010 i_trig_ch, i_trig_fall  in  1 each  trigger channel select; 0 = rising slope, 1 = falling slope.
REQ-011 i_trig_level  in  10  trigger threshold, unsigned.
REQ-012 i_decim  in  8  store every (i_decim+1)th sample pair.
REQ-013 o_wr_en, o_wr_addr, o_wr_data  out  1, ADDR_W, 20  buffer write port; o_wr_data = {ch1, ch0}.
REQ-014 o_state  out  3  current state encoding, from the package enum.
REQ-015 o_capture_done, o_forced  out  1 each  capture complete (level); trigger was forced (level).
REQ-016 o_start_addr  out  ADDR_W  address of the oldest sample in the completed record.

Function
REQ-017 A pair event is a cycle with i_done=1 where i_done was 0 in the previous cycle; every second done edge is a pair event, tracked by a parity bit that is cleared by reset only.
REQ-018 A decimation counter counts pair events, wraps at i_decim, and is cleared on arm; a pair is stored when the counter equals 0.
REQ-019 A stored pair asserts o_wr_en for exactly one cycle, the cycle after the pair event, with o_wr_data = {i_data1, i_data0} as sampled at the event.
REQ-020 o_wr_addr increments by 1 modulo DEPTH after each write; it wraps from DEPTH-1 to 0 without a gap.
REQ-021 States: IDLE, PREFILL, ARMED, POST, DONE.
REQ-022 IDLE: no writes; on i_arm, clear the address, counters, o_capture_done and o_forced, then go to PREFILL.
REQ-023 PREFILL: store pairs; after PRETRIG writes, go to ARMED.
REQ-024 ARMED: keep storing. Trigger when the selected channel of the current stored pair crosses the threshold against the previous stored pair:
  - rising slope: prev < level and cur >= level;
  - falling slope: prev > level and cur <= level.
REQ-025 The first stored pair after arm has no predecessor and never triggers.
REQ-026 Auto mode: if i_auto=1 and AUTO_TIMEOUT pairs are stored in ARMED without a trigger, the next stored pair is the trigger and o_forced is set.
REQ-027 Trigger: record trigger address = that pair's write address, then go to POST; the trigger pair counts as the first post-trigger sample.
REQ-028 POST: after DEPTH-PRETRIG total post-trigger writes, go to DONE.
REQ-029 DONE: o_capture_done=1; o_start_addr = (trigger address - PRETRIG) mod DEPTH; no writes; i_arm restarts the sequence as in IDLE.
REQ-030 i_arm is ignored in PREFILL, ARMED and POST.
REQ-031 i_abort in any state returns to IDLE next cycle and suppresses any pending write; abort wins over a simultaneous arm or trigger.
REQ-032 Changes to trigger inputs take effect on the next stored pair; i_decim changes take effect at the next counter wrap.

Reset
REQ-033 On i_rst: state IDLE; o_wr_en, o_wr_addr, o_wr_data, o_capture_done, o_forced and o_start_addr are 0; the parity bit, decimation counter, timeout counter and previous-sample register are 0.
REQ-034 Reset mid-capture discards the capture; no write occurs in the reset cycle.

Structure
REQ-035 Package scope_pkg holds the state enum, the SAMPLE_W=10 constant and the pair struct {ch1, ch0}.
REQ-036 Threshold/slope comparison lives in sub-module scope_trig_detect: combinational, inputs prev, cur, level, fall; output hit.

Verification
REQ-037 The bench uses ADDR_W=4 and PRETRIG=4, with i_done pulsed every 32 cycles.
REQ-038 Scenario: arm, i_decim=0, channel-0 ramp 0,10,20,..., level=35 rising -> trigger on the pair with value 40; o_start_addr = trig-4 mod 16; exactly 16 writes, then DONE.
REQ-039 Scenario: falling slope, level=35, ramp descending 100,90,... -> trigger at value 30; rising crossings never trigger.
REQ-040 Scenario: i_decim=2 -> writes on every 3rd pair only, i.e. every 6th done pulse.
REQ-041 Scenario: constant input, i_auto=1, AUTO_TIMEOUT=8 -> forced trigger on the 9th ARMED pair; o_forced=1.
REQ-042 Scenario: abort during POST, then re-arm -> no write in the abort cycle; address restarts at 0.
REQ-043 Scenario: i_rst mid-PREFILL, and arm during ARMED -> all outputs 0 after reset; the arm during ARMED is ignored.
